// File: rtl/echo_window_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : echo_window_capture                                        |
// | Description : Triggered capture of a window of 12-bit ADC samples.       |
// |               After a trigger the block skips a programmable number of   |
// |               received words. It then stores the next DEPTH samples in   |
// |               on-chip RAM and tracks the peak sample and its index. A    |
// |               registered random-access read port exposes the window.     |
// | Ports       : clk, rst          - clock, synchronous active-high reset   |
// |               iWORD/iWORD_VALID - received ADC word and its strobe       |
// |               iTRIG, iDELAY     - start pulse and words to skip          |
// |               iRD_ADDR/oRD_DATA - read port, 1-cycle latency             |
// |               oBUSY, oDONE      - skipping/capturing, window complete    |
// |               oCOUNT            - samples written in this/last window    |
// |               oPEAK, oPEAK_IDX  - peak sample and first index of it      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module echo_window_capture #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       iWORD,
  input  logic              iWORD_VALID,
  input  logic              iTRIG,
  input  logic [15:0]       iDELAY,
  input  logic [ADDR_W-1:0] iRD_ADDR,
  output logic [11:0]       oRD_DATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic [ADDR_W:0]   oCOUNT,
  output logic [11:0]       oPEAK,
  output logic [ADDR_W-1:0] oPEAK_IDX
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Count value held just before the final write of a window.
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [15:0]         skip_q, skip_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [11:0]         peak_q, peak_d;
  logic [ADDR_W-1:0]   peak_idx_q, peak_idx_d;
  logic [11:0]         rd_data_q;
  logic                mem_we;
  logic [11:0]         sample;

  logic [11:0]         mem [DEPTH];

  // Upper nibble of the ADC word carries no sample information.
  logic                unused_word_bits;
  assign unused_word_bits = ^iWORD[15:12];

  assign sample = iWORD[11:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    wr_addr_d  = wr_addr_q;
    count_d    = count_q;
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    mem_we     = 1'b0;

    case (state_q)
      // A word strobed in the trigger cycle itself is pre-trigger, so
      // acceptance ignores iWORD_VALID entirely.
      ST_IDLE, ST_DONE: begin
        if (iTRIG) begin
          skip_d     = iDELAY;
          wr_addr_d  = '0;
          count_d    = '0;
          peak_d     = '0;
          peak_idx_d = '0;
          state_d    = (iDELAY == 16'd0) ? ST_CAPTURE : ST_DELAY;
        end
      end

      // The word that takes the counter from 1 to 0 is itself discarded.
      ST_DELAY: begin
        if (iWORD_VALID) begin
          skip_d = skip_q - 16'd1;
          if (skip_q == 16'd1) begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (iWORD_VALID) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          count_d   = count_q + (ADDR_W+1)'(1);
          // The first write always seeds the peak; later writes need a strict
          // increase so ties keep the earliest index.
          if ((count_q == '0) || (sample > peak_q)) begin
            peak_d     = sample;
            peak_idx_d = wr_addr_q;
          end
          if (count_q == LAST_COUNT) begin
            state_d = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      wr_addr_q  <= '0;
      count_q    <= '0;
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      wr_addr_q  <= wr_addr_d;
      count_q    <= count_d;
      peak_q     <= peak_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sample RAM: no reset, so it maps onto block RAM. The read register sees
  // the pre-write contents when reading the address being written.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr_q] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[iRD_ADDR];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign oRD_DATA  = rd_data_q;
  assign oBUSY     = (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
  assign oDONE     = (state_q == ST_DONE);
  assign oCOUNT    = count_q;
  assign oPEAK     = peak_q;
  assign oPEAK_IDX = peak_idx_q;

endmodule
`default_nettype wire
